// File: rtl/rr_stream_arb.sv
// Packet-aware round-robin arbiter: NUM_REQ valid/ready streams share one registered output.
// A granted packet owns the output until its last beat transfers.
module rr_stream_arb #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DWIDTH  = 32,
    parameter int unsigned SELW    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        s_valid,
    input  logic [NUM_REQ*DWIDTH-1:0] s_data,
    input  logic [NUM_REQ-1:0]        s_last,
    output logic [NUM_REQ-1:0]        s_ready,
    output logic                      m_valid,
    output logic [DWIDTH-1:0]         m_data,
    output logic                      m_last,
    output logic [SELW-1:0]           m_sel,
    input  logic                      m_ready,
    output logic                      busy
);

    typedef enum logic [0:0] {
        StIdle,
        StLocked
    } state_e;

    state_e            state_q, state_d;
    logic [SELW-1:0]   ptr_q, ptr_d;
    logic [SELW-1:0]   lock_idx_q, lock_idx_d;
    logic              m_valid_q, m_valid_d;
    logic [DWIDTH-1:0] m_data_q, m_data_d;
    logic              m_last_q, m_last_d;
    logic [SELW-1:0]   m_sel_q, m_sel_d;

    logic [SELW:0]     rr_sum;
    logic [SELW-1:0]   rr_cand;
    logic [SELW-1:0]   rr_idx;
    logic              rr_found;

    logic [SELW-1:0]   g;
    logic              gv;
    logic              accept;
    logic              xfer;
    logic [DWIDTH-1:0] g_data;
    logic              g_last;
    logic [SELW-1:0]   g_inc;

    // Rotating priority scan: ptr, ptr+1, ..., wrapping modulo NUM_REQ.
    always_comb begin
        rr_sum   = '0;
        rr_cand  = '0;
        rr_idx   = ptr_q;
        rr_found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            rr_sum = {1'b0, ptr_q} + (SELW+1)'(k);
            if (rr_sum >= (SELW+1)'(NUM_REQ)) begin
                rr_sum = rr_sum - (SELW+1)'(NUM_REQ);
            end
            rr_cand = rr_sum[SELW-1:0];
            if (!rr_found && s_valid[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
    end

    always_comb begin
        if (state_q == StLocked) begin
            g  = lock_idx_q;
            gv = s_valid[lock_idx_q];
        end else begin
            g  = rr_idx;
            gv = rr_found;
        end
    end

    assign accept = !m_valid_q || m_ready;
    assign xfer   = gv && accept;
    assign g_data = s_data[32'(g)*DWIDTH +: DWIDTH];
    assign g_last = s_last[g];
    assign g_inc  = (g == SELW'(NUM_REQ - 1)) ? '0 : g + SELW'(1);

    // Ready depends only on the grant, never on other requesters' valid.
    always_comb begin
        s_ready = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            s_ready[i] = !rst && accept && gv && (g == SELW'(i));
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        lock_idx_d = lock_idx_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        m_last_d   = m_last_q;
        m_sel_d    = m_sel_q;

        if (xfer) begin
            m_valid_d = 1'b1;
            m_data_d  = g_data;
            m_last_d  = g_last;
            m_sel_d   = g;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (xfer) begin
                    if (g_last) begin
                        ptr_d = g_inc;
                    end else begin
                        state_d    = StLocked;
                        lock_idx_d = g;
                    end
                end
            end
            StLocked: begin
                if (xfer && g_last) begin
                    state_d = StIdle;
                    ptr_d   = g_inc;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            lock_idx_q <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_last_q   <= 1'b0;
            m_sel_q    <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            lock_idx_q <= lock_idx_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_last_q   <= m_last_d;
            m_sel_q    <= m_sel_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;
    assign m_sel   = m_sel_q;
    assign busy    = (state_q == StLocked);

endmodule

// File: doc/rr_stream_arb.md
Name: rr_stream_arb

Overview:
- Round-robin, packet-aware arbiter that shares one valid/ready stream channel among NUM_REQ requesters.
- Sits in front of the shared pipeline stage chain. It feeds a downstream sink, or a bwd/fwd pipe cascade, through one internal registered output stage.
- Once a packet is granted, the grant is held until that packet's last beat transfers. Packets from different requesters never interleave.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- DWIDTH, 32, data width per requester.
- SELW, 2, width of the grant index; must equal max(1, ceil(log2(NUM_REQ))).

Ports:
- clk  input  1  clock, all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- s_valid  input  NUM_REQ  per-requester valid; bit i belongs to requester i.
- s_data  input  NUM_REQ*DWIDTH  flattened data; requester i occupies bits [i*DWIDTH +: DWIDTH].
- s_last  input  NUM_REQ  per-requester end-of-packet flag.
- s_ready  output  NUM_REQ  per-requester ready.
- m_valid  output  1  output beat valid.
- m_data  output  DWIDTH  output beat data.
- m_last  output  1  output end-of-packet flag.
- m_sel  output  SELW  index of the requester that produced the current output beat.
- m_ready  input  1  downstream ready.
- busy  output  1  high while a multi-beat packet holds the grant (LOCKED state).

Behaviour:

Reset (rst=1 at a clock edge):
- m_valid=0, m_data=0, m_last=0, m_sel=0, busy=0.
- state=IDLE, ptr=0.
- While rst=1, s_ready is forced to all zeros.

Output acceptance:
- accept = !m_valid || m_ready. The output register accepts a new beat only when it is empty or is draining this cycle.

Grant, combinational each cycle:
- IDLE: g = first i with s_valid[i]=1, scanning ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1. gv = |s_valid.
- LOCKED: g = lock_idx and gv = s_valid[lock_idx]. Other requesters are ignored even when valid.
- s_ready[i] = !rst && accept && gv && (i==g). At most one bit is set per cycle.
- s_ready does not depend on s_valid[i] of non-granted requesters.

Transfer:
- xfer = gv && accept. On xfer: m_valid<=1, m_data<=s_data[g], m_last<=s_last[g], m_sel<=g.
- Else if m_ready: m_valid<=0, and m_data, m_last and m_sel hold their values.
- Latency: input handshake cycle N gives m_valid in cycle N+1.
- Full throughput: one beat per cycle while m_ready=1 and requests are present.
- m_valid, m_data, m_last and m_sel are stable while m_valid=1 and m_ready=0.

State machine (IDLE, LOCKED):
- IDLE, xfer with s_last[g]=0: go to LOCKED, lock_idx<=g, busy<=1.
- IDLE, xfer with s_last[g]=1 (single-beat packet): stay IDLE, ptr<=(g+1) mod NUM_REQ.
- LOCKED, xfer with s_last[lock_idx]=1: go to IDLE, ptr<=(lock_idx+1) mod NUM_REQ, busy<=0.
- LOCKED, xfer with s_last=0, or no xfer: stay LOCKED.
- ptr changes only on a last-beat transfer. ptr wraps from NUM_REQ-1 to 0.

Boundary conditions:
- Granted requester drops valid mid-packet in LOCKED: the grant is held and the output bubbles. No other requester is served.
- m_ready=0 with the output register full: accept=0, all s_ready=0, state and ptr frozen.
- Output draining and a new beat transferring in the same cycle: the register is overwritten with the new beat and m_valid stays 1.
- Only one requester valid: it is granted every cycle, regardless of ptr.
- rst asserted mid-packet: the in-flight output beat is discarded, state returns to IDLE and ptr to 0 on the next edge.
- Unused m_sel upper code points never occur.

Test Plan:
1. Reset: rst=1 for 2 cycles with s_valid=4'b1111 → s_ready=0, m_valid=0, m_sel=0, busy=0. After rst falls, the first grant goes to requester 0.
2. Round-robin single beats: s_valid=4'b1111, all s_last=1, m_ready=1, data[i]=0x10+i → m_data sequence 0x10,0x11,0x12,0x13,0x10 on consecutive cycles, each one cycle after its handshake; m_sel 0,1,2,3,0.
3. Packet lock: requester 1 sends 3 beats (last on the 3rd) while requesters 0 and 2 stay valid → m_sel=1 for 3 consecutive beats with busy=1. The next grant goes to 2 (not 0) and busy=0.
4. Backpressure: m_ready=0 for 4 cycles with m_valid=1, m_data=0xAB → m_data, m_sel and m_last hold, all s_ready=0, ptr unchanged. Releasing m_ready resumes with no beat lost or duplicated.
5. Mid-packet bubble: the locked requester 3 deasserts valid for 2 cycles while requester 0 is valid → s_ready[0] stays 0 and m_valid drops to 0. Requester 3 resumes and completes its packet, then requester 0 is granted.
6. Reset mid-packet: assert rst while busy=1 and m_valid=1 → the next cycle shows m_valid=0, busy=0, and the next grant goes to the lowest valid index starting from requester 0.
